// File: rtl/ram_tile_reader.sv
// Walks a rows x cols tile in the scratchpad RAM and streams the words out over valid/ready.
// Reads are issued only against free FIFO credit, so every returned word has a slot.
module ram_tile_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter int DIM_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  num_rows,
  input  logic [DIM_WIDTH-1:0]  num_cols,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_read_req,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  empty_tile_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [DIM_WIDTH-1:0]  col_q;
  logic [DIM_WIDTH-1:0]  row_q;
  logic [DIM_WIDTH-1:0]  rows_q;
  logic [DIM_WIDTH-1:0]  cols_q;

  logic [DATA_WIDTH:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic                  issue;
  logic                  last_col;
  logic                  last_elem;
  logic                  credit_ok;
  logic [CNT_W:0]        credit_used;
  logic                  inflight;
  logic                  push;
  logic                  push_last;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] next_row_base;

  assign last_col      = (col_q == cols_q - DIM_WIDTH'(1));
  assign last_elem     = last_col && (row_q == rows_q - DIM_WIDTH'(1));
  assign next_row_base = row_base_q + stride_q;

  // Credit counts both buffered words and reads whose data has not come back yet.
  assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
  assign credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue       = (state_q == S_RUN) && credit_ok;

  assign pop = out_valid && out_ready;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      logic pend_valid_q;
      logic pend_last_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          pend_valid_q <= 1'b0;
          pend_last_q  <= 1'b0;
        end else begin
          pend_valid_q <= issue;
          pend_last_q  <= issue && last_elem;
        end
      end

      assign inflight  = pend_valid_q;
      assign push      = pend_valid_q;
      assign push_last = pend_last_q;
    end else begin : g_lat0
      assign inflight  = 1'b0;
      assign push      = issue;
      assign push_last = issue && last_elem;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {push_last, ram_read_data};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      empty_tile_q <= 1'b0;
      addr_q       <= '0;
      row_base_q   <= '0;
      stride_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rows_q     <= num_rows;
            cols_q     <= num_cols;
            stride_q   <= row_stride;
            row_base_q <= base_addr;
            col_q      <= '0;
            row_q      <= '0;
            busy_q     <= 1'b1;
            // An empty tile still spends one busy cycle so done lands at the same offset.
            if (num_rows == '0 || num_cols == '0) begin
              empty_tile_q <= 1'b1;
              state_q      <= S_DRAIN;
            end else begin
              empty_tile_q <= 1'b0;
              addr_q       <= base_addr;
              state_q      <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            if (last_elem) begin
              state_q <= S_DRAIN;
            end else if (last_col) begin
              col_q      <= '0;
              row_q      <= row_q + DIM_WIDTH'(1);
              row_base_q <= next_row_base;
              addr_q     <= next_row_base;
            end else begin
              col_q  <= col_q + DIM_WIDTH'(1);
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (empty_tile_q || (pop && out_last)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign ram_read_req  = issue;
  assign ram_read_addr = addr_q;
  assign out_valid     = (count_q != '0);
  assign out_data      = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign out_last      = out_valid && fifo_q[rd_ptr_q][DATA_WIDTH];

endmodule

// File: tb/tb_ram_tile_reader.sv
// Bench for ram_tile_reader: a vector table of tiles run through a scoreboard on a
// READ_LATENCY=1 instance, plus hand sequences for reset, empty tiles and READ_LATENCY=0.
module tb_ram_tile_reader;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DIMW  = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            start1;
  logic            start0;
  logic [AW-1:0]   base;
  logic [DIMW-1:0] rows;
  logic [DIMW-1:0] cols;
  logic [AW-1:0]   stride;
  logic            out_ready;

  logic            busy1, done1, req1, valid1, last1;
  logic [AW-1:0]   addr1;
  logic [DW-1:0]   rdata1, data1;
  logic            busy0, done0, req0, valid0, last0;
  logic [AW-1:0]   addr0;
  logic [DW-1:0]   rdata0, data0;

  logic [DW-1:0]   mem1 [0:4095];
  logic [DW-1:0]   mem0 [0:4095];

  ram_tile_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .DIM_WIDTH(DIMW), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base), .num_rows(rows), .num_cols(cols),
    .row_stride(stride), .busy(busy1), .done(done1), .ram_read_req(req1), .ram_read_addr(addr1),
    .ram_read_data(rdata1), .out_valid(valid1), .out_data(data1), .out_last(last1), .out_ready(out_ready)
  );

  ram_tile_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(0), .DIM_WIDTH(DIMW), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .base_addr(base), .num_rows(rows), .num_cols(cols),
    .row_stride(stride), .busy(busy0), .done(done0), .ram_read_req(req0), .ram_read_addr(addr0),
    .ram_read_data(rdata0), .out_valid(valid0), .out_data(data0), .out_last(last0), .out_ready(out_ready)
  );

  // Registered-output RAM for dut1, combinational RAM for dut0.
  always @(posedge clk) begin
    if (req1) rdata1 <= mem1[addr1];
  end
  assign rdata0 = mem0[addr0];

  typedef struct {
    logic [AW-1:0]   base;
    logic [DIMW-1:0] rows;
    logic [DIMW-1:0] cols;
    logic [AW-1:0]   stride;
    int              mode;
    int              exp_reads;
    logic [AW-1:0]   exp_last_addr;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  vec_t          vecs [5];
  logic [AW-1:0] exp_addr_q [$];
  beat_t         exp_beat_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mode = 0;
  int issued, accepted, total, first_req, first_valid, last_xfer, done_cnt, done_at, stall_cycles;
  bit            prev_hold;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    exp_addr_q.delete();
    exp_beat_q.delete();
    issued = 0; accepted = 0; total = 0;
    first_req = -1; first_valid = -1; last_xfer = -1;
    done_cnt = 0; done_at = -1; stall_cycles = 0;
    prev_hold = 1'b0;
  endtask

  // Advance one cycle, drive out_ready for it, then check dut1 against the scoreboard.
  task automatic step();
    int    k;
    beat_t b;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc - start_cyc;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (k >= 8);
    endcase
    if (prev_hold) begin
      chk("hold_valid", 32'(valid1), 32'd1);
      chk("hold_data", 32'(data1), 32'(prev_data));
      chk("hold_last", 32'(last1), 32'(prev_last));
    end
    if (req1) begin
      if (first_req < 0) first_req = k;
      chk("credit", 32'((issued - accepted) < DEPTH), 32'd1);
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_read: got addr 0x%0h expected no read (cycle %0d)", addr1, cyc);
      end else begin
        chk("read_addr", 32'(addr1), 32'(exp_addr_q.pop_front()));
      end
      issued++;
    end else if (busy1 && issued < total) begin
      stall_cycles++;
    end
    if (valid1 && first_valid < 0) first_valid = k;
    if (valid1 && out_ready) begin
      accepted++;
      if (exp_beat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_beat: got data 0x%0h expected no beat (cycle %0d)", data1, cyc);
      end else begin
        b = exp_beat_q.pop_front();
        chk("out_data", 32'(data1), 32'(b.data));
        chk("out_last", 32'(last1), 32'(b.last));
      end
      if (last1) last_xfer = cyc;
    end
    prev_hold = valid1 && !out_ready;
    prev_data = data1;
    prev_last = last1;
    if (done1) begin
      done_cnt++;
      done_at = cyc;
      chk("busy_in_done", 32'(busy1), 32'd0);
    end
  endtask

  // Build the expected stream for a tile, pulse start for one cycle, end in cycle T+1.
  task automatic launch(input vec_t v);
    logic [AW-1:0] a;
    beat_t         b;
    clear_mon();
    total = int'(v.rows) * int'(v.cols);
    for (int r = 0; r < int'(v.rows); r++) begin
      for (int c = 0; c < int'(v.cols); c++) begin
        a = AW'(int'(v.base) + r * int'(v.stride) + c);
        exp_addr_q.push_back(a);
        b.data = a[DW-1:0];
        b.last = (r == int'(v.rows) - 1) && (c == int'(v.cols) - 1);
        exp_beat_q.push_back(b);
      end
    end
    mode   = v.mode;
    base   = v.base;
    rows   = v.rows;
    cols   = v.cols;
    stride = v.stride;
    start1 = 1'b1;
    start_cyc = cyc;
    step();
    start1 = 1'b0;
    chk("busy_after_start", 32'(busy1), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    launch(v);
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      step();
      n++;
    end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles (cycle %0d)", cyc);
    end
    step();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("reads_issued", 32'(issued), 32'(v.exp_reads));
    chk("scoreboard_empty", 32'(exp_addr_q.size() + exp_beat_q.size()), 32'd0);
    chk("first_req_latency", 32'(first_req), 32'd1);
    chk("first_valid_latency", 32'(first_valid), 32'd3);
    chk("done_after_last", 32'(done_at - last_xfer), 32'd1);
    chk("addr_held", 32'(addr1), 32'(v.exp_last_addr));
    if (v.mode == 3) chk("credit_stall_seen", 32'(stall_cycles > 0), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = 8'(i);
      mem0[i] = 8'(i);
    end
    mem0[5] = 8'hFD;

    vecs[0] = '{12'h010, 8'd2, 8'd3, 12'h020, 0, 6, 12'h032};
    vecs[1] = '{12'h010, 8'd2, 8'd3, 12'h020, 1, 6, 12'h032};
    vecs[2] = '{12'hFFE, 8'd1, 8'd4, 12'h000, 0, 4, 12'h001};
    vecs[3] = '{12'h100, 8'd3, 8'd5, 12'h008, 3, 15, 12'h114};
    vecs[4] = '{12'h7F0, 8'd4, 8'd3, 12'h405, 2, 12, 12'h401};

    reset = 1'b1; start1 = 1'b0; start0 = 1'b0;
    base = '0; rows = '0; cols = '0; stride = '0; out_ready = 1'b1;
    clear_mon();
    repeat (3) step();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_req", 32'(req1), 32'd0);
    chk("rst_addr", 32'(addr1), 32'd0);
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_data", 32'(data1), 32'd0);
    chk("rst_last", 32'(last1), 32'd0);
    chk("rst_l0_outputs", 32'({busy0, done0, req0, valid0, last0, addr0, data0}), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      repeat (2) step();
    end

    // Empty tile: no reads, no data, done two cycles after start.
    clear_mon();
    mode = 0; base = 12'h040; rows = 8'd3; cols = 8'd0; stride = 12'h010;
    start1 = 1'b1; start_cyc = cyc;
    step();
    start1 = 1'b0;
    chk("zero_busy_t1", 32'(busy1), 32'd1);
    chk("zero_done_t1", 32'(done1), 32'd0);
    step();
    chk("zero_done_t2", 32'(done1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zero_quiet", 32'({done1, busy1, req1, valid1}), 32'd0);
    end

    // Reset after two of six reads: immediate abort, no done, then a clean rerun.
    launch(vecs[0]);
    for (int n = 0; n < 20 && issued < 2; n++) step();
    chk("pre_reset_reads", 32'(issued), 32'd2);
    reset = 1'b1;
    step();
    chk("abort_outputs", 32'({busy1, done1, req1, valid1, last1, addr1, data1}), 32'd0);
    reset = 1'b0;
    clear_mon();
    repeat (8) step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_vec(vecs[0]);
    repeat (2) step();

    // READ_LATENCY=0: 1x1 tile at address 5, with a second start while busy.
    mode = 0; base = 12'h005; rows = 8'd1; cols = 8'd1; stride = 12'h000;
    start0 = 1'b1;
    step();
    chk("l0_req", 32'(req0), 32'd1);
    chk("l0_addr", 32'(addr0), 32'h005);
    chk("l0_busy", 32'(busy0), 32'd1);
    base = 12'h007;
    step();
    start0 = 1'b0;
    chk("l0_valid_t2", 32'(valid0), 32'd1);
    chk("l0_data_t2", 32'(data0), 32'h0FD);
    chk("l0_last_t2", 32'(last0), 32'd1);
    chk("l0_no_second_req", 32'(req0), 32'd0);
    step();
    chk("l0_done", 32'(done0), 32'd1);
    chk("l0_valid_after", 32'(valid0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("l0_ignored_start", 32'({req0, valid0, done0, busy0}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_tile_reader.md
Name: ram_tile_reader

Overview:
Address-generation and read-stream stage that sits directly downstream of the NPU scratchpad ram block. It walks a 2-D tile (rows x cols, programmable row stride) in the ram and drives read_req/read_addr. It captures the returned read_data, compensating for the ram's 0- or 1-cycle read latency. It presents the data as a valid/ready stream to the PE array feeder, with credit-based backpressure so no read result is ever dropped.

Parameters:
DATA_WIDTH, 8, width of ram word and output stream data
ADDR_WIDTH, 12, ram address width; all address arithmetic is modulo 2^ADDR_WIDTH
READ_LATENCY, 1, ram read latency in cycles (0 = combinational read, 1 = registered output); only 0 and 1 are legal
DIM_WIDTH, 8, width of num_rows/num_cols counters
FIFO_DEPTH, 4, output buffer entries; must be >= READ_LATENCY+2 (power of two)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; latches tile descriptor when idle
base_addr  input  ADDR_WIDTH  address of tile element (0,0)
num_rows  input  DIM_WIDTH  tile rows
num_cols  input  DIM_WIDTH  tile columns (contiguous words per row)
row_stride  input  ADDR_WIDTH  address delta between consecutive row starts
busy  output  1  high from the cycle after an accepted start until the done cycle
done  output  1  one-cycle pulse when the transfer completes
ram_read_req  output  1  read request to ram
ram_read_addr  output  ADDR_WIDTH  read address to ram
ram_read_data  input  DATA_WIDTH  signed read data from ram
out_valid  output  1  stream data valid
out_data  output  DATA_WIDTH  stream data (signed, unmodified ram word)
out_last  output  1  high with the final element of the tile
out_ready  input  1  downstream accept

Behaviour:
- Reset values: busy=0, done=0, ram_read_req=0, ram_read_addr=0, out_valid=0, out_data=0, out_last=0. FSM goes to IDLE; FIFO, counters and in-flight pipe are cleared.
- Reset mid-transfer aborts immediately. No done pulse. Data in flight or buffered is discarded.
- FSM states:
  - IDLE: start=1 latches the descriptor. If num_rows==0 or num_cols==0 -> DONE (no reads). Otherwise -> RUN.
  - RUN: issues reads. After the read of the last element is issued -> DRAIN.
  - DRAIN: waits until the last element is accepted (out_valid&out_ready&out_last) -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- Address walk:
  - addr = row_base + col, with row_base starting at base_addr; col counts 0..num_cols-1.
  - On col wrap, row_base += row_stride. Row-major order.
  - All sums truncate to ADDR_WIDTH, so wrap past 2^ADDR_WIDTH-1 goes to 0.
- Read issue:
  - ram_read_req=1 in RUN only when credit is available: (fifo_count + reads_in_flight) < FIFO_DEPTH.
  - ram_read_addr is valid whenever ram_read_req=1 and holds its value otherwise.
- Data capture:
  - A read issued in cycle C is sampled from ram_read_data at the end of cycle C+READ_LATENCY and written to the FIFO.
  - The FIFO is registered, so data is visible on out_valid/out_data at cycle C+READ_LATENCY+1.
  - A per-entry last flag is carried alongside the data.
- Latency: start at cycle T gives the first ram_read_req at T+1. The first out_valid is at T+2 (READ_LATENCY=0) or T+3 (READ_LATENCY=1).
- Throughput: with out_ready held high, one element per cycle sustained.
- Stream rules:
  - Transfer when out_valid&out_ready.
  - out_data/out_last are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Simultaneous FIFO push and pop when full or empty are both legal; the count is unchanged.
- A 1x1 tile produces one element with out_last=1.
- done is asserted the cycle after the last transfer. busy falls in the same cycle done is asserted.

Test Plan:
- READ_LATENCY=1; ram preloaded mem[a]=a&0xFF; start with base=0x010, rows=2, cols=3, stride=0x020; out_ready=1 -> reads at 0x010,011,012,030,031,032 on consecutive cycles; out_data 0x10,0x11,0x12,0x30,0x31,0x32; first out_valid at T+3; out_last only on 0x32; done one cycle after.
- Same tile with out_ready toggling 1,0,0,1 repeating -> identical ordered data; no loss or duplication; ram_read_req stalls once credits hit FIFO_DEPTH; out_data stable during stalls.
- base=0xFFE, rows=1, cols=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
- num_cols=0 -> no ram_read_req, no out_valid, done pulses at T+2; busy high only in the done cycle window.
- Reset asserted mid-RUN after 2 of 6 elements -> next cycle all outputs at reset values, no done. A subsequent start runs a fresh, complete tile.
- READ_LATENCY=0, 1x1 tile with mem[5]=-3 -> out_data=0xFD with out_last=1 at T+2; a start pulse during busy is ignored.
